// File: rtl/full_adder_unit.sv
// Ripple-carry full adder with a zero-latency combinational result and a 1-cycle registered copy.
// Registered path has no backpressure: every in_valid cycle is captured; idle cycles hold sum/cout.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder_unit #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_comb,
    output logic             cout_comb,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    assign carry[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_bits[i]),
            .co (carry[i+1])
        );
    end

    assign sum_comb  = sum_bits;
    assign cout_comb = carry[WIDTH];

    // Data registers only load on accepted inputs so idle (possibly X) inputs never leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_comb;
                cout <= cout_comb;
            end
        end
    end
endmodule

// File: tb/tb_full_adder_unit.sv
// Directed and random checks of full_adder_unit at WIDTH 1, 8 and 16.
module tb_full_adder_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic        a1, b1, c1, v1, sc1, cc1, s1, co1, ov1;
    logic [7:0]  a8, b8, sc8, s8;
    logic        c8, v8, cc8, co8, ov8;
    logic [15:0] a16, b16, sc16, s16;
    logic        c16, v16, cc16, co16, ov16;

    always #5 clk = ~clk;

    full_adder_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .in_valid(v1),
        .sum_comb(sc1), .cout_comb(cc1), .sum(s1), .cout(co1), .out_valid(ov1));
    full_adder_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .in_valid(v8),
        .sum_comb(sc8), .cout_comb(cc8), .sum(s8), .cout(co8), .out_valid(ov8));
    full_adder_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c(c16), .in_valid(v16),
        .sum_comb(sc16), .cout_comb(cc16), .sum(s16), .cout(co16), .out_valid(ov16));

    // Truth table for (a,b,c) = 0..7, indexed by {a,b,c}.
    logic [7:0] exp_sum_tbl  = 8'b1001_0110;
    logic [7:0] exp_cout_tbl = 8'b1110_1000;

    task automatic test_reset();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
        a16 = 16'h1234; b16 = 16'h1111; c16 = 1'b0; v16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s1, co1, ov1} !== 3'b000) begin
            errors++; $display("FAIL reset_w1: got %b expected 000", {s1, co1, ov1});
        end
        checks++;
        if ({s8, co8, ov8} !== 10'h000) begin
            errors++; $display("FAIL reset_w8: got %h/%b/%b expected 00/0/0", s8, co8, ov8);
        end
        checks++;
        if ({s16, co16, ov16} !== 18'h0) begin
            errors++; $display("FAIL reset_w16: got %h/%b/%b expected 0000/0/0", s16, co16, ov16);
        end
        checks++;
        if ({cc8, sc8} !== 9'h100) begin
            errors++; $display("FAIL reset_comb_live: got %h expected 100", {cc8, sc8});
        end
        v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb_sweep();
        logic [2:0] abc;
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            {a1, b1, c1} = abc;
            #20;
            checks++;
            if ({sc1, cc1} !== {exp_sum_tbl[i], exp_cout_tbl[i]}) begin
                errors++;
                $display("FAIL comb_sweep[%0d]: got sum/cout %b/%b expected %b/%b",
                         i, sc1, cc1, exp_sum_tbl[i], exp_cout_tbl[i]);
            end
        end
    endtask

    task automatic test_reg_sweep();
        logic [2:0] abc;
        @(posedge clk);
        #1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                checks++;
                if ({s1, co1, ov1} !== {exp_sum_tbl[i-1], exp_cout_tbl[i-1], 1'b1}) begin
                    errors++;
                    $display("FAIL reg_sweep[%0d]: got sum/cout/valid %b/%b/%b expected %b/%b/1",
                             i - 1, s1, co1, ov1, exp_sum_tbl[i-1], exp_cout_tbl[i-1]);
                end
            end
            if (i < 8) begin
                abc = 3'(i);
                {a1, b1, c1} = abc;
                v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wide8();
        logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h12};
        logic [7:0] vb [3] = '{8'h01, 8'h80, 8'h34};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [8:0] ve [3] = '{9'h100, 9'h100, 9'h047};
        for (int i = 0; i < 3; i++) begin
            a8 = va[i]; b8 = vb[i]; c8 = vc[i]; v8 = 1'b1;
            #1;
            checks++;
            if ({cc8, sc8} !== ve[i]) begin
                errors++; $display("FAIL wide8_comb[%0d]: got %h expected %h", i, {cc8, sc8}, ve[i]);
            end
            @(posedge clk);
            #1;
            v8 = 1'b0;
            checks++;
            if ({ov8, co8, s8} !== {1'b1, ve[i]}) begin
                errors++;
                $display("FAIL wide8_reg[%0d]: got valid/cout:sum %b/%h expected 1/%h", i, ov8, {co8, s8}, ve[i]);
            end
        end
    endtask

    task automatic test_hold();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({s1, co1, ov1} !== 3'b111) begin
            errors++; $display("FAIL hold_capture: got %b expected 111", {s1, co1, ov1});
        end
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; end
                1: begin a1 = 1'bx; b1 = 1'b1; c1 = 1'bx; end
                default: begin a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; end
            endcase
            @(posedge clk);
            #1;
            checks++;
            if ({s1, co1, ov1} !== 3'b110) begin
                errors++; $display("FAIL hold[%0d]: got sum/cout/valid %b expected 110", k, {s1, co1, ov1});
            end
        end
    endtask

    task automatic test_async_reset();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if ({s1, co1, ov1} !== 3'b111) begin
            errors++; $display("FAIL areset_pre: got %b expected 111", {s1, co1, ov1});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s1, co1, ov1} !== 3'b000) begin
            errors++; $display("FAIL areset_async: got %b expected 000", {s1, co1, ov1});
        end
        checks++;
        if ({sc1, cc1} !== 2'b11) begin
            errors++; $display("FAIL areset_comb_live: got %b expected 11", {sc1, cc1});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({s1, co1, ov1} !== 3'b000) begin
            errors++; $display("FAIL areset_discard: got %b expected 000", {s1, co1, ov1});
        end
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        checks++;
        if ({s1, co1, ov1} !== 3'b011) begin
            errors++; $display("FAIL areset_first_capture: got %b expected 011", {s1, co1, ov1});
        end
    endtask

    task automatic test_back_to_back_random16();
        logic [16:0] exp_v;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            v16 = 1'b1;
            exp_v = {1'b0, a16} + {1'b0, b16} + {16'b0, c16};
            #1;
            checks++;
            if ({cc16, sc16} !== exp_v) begin
                errors++;
                $display("FAIL rand16_comb[%0d]: a=%h b=%h c=%b got %h expected %h", i, a16, b16, c16, {cc16, sc16}, exp_v);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({ov16, co16, s16} !== {1'b1, exp_v}) begin
                errors++;
                $display("FAIL rand16_reg[%0d]: got valid/cout:sum %b/%h expected 1/%h", i, ov16, {co16, s16}, exp_v);
            end
        end
        v16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb_sweep();
        test_reg_sweep();
        test_wide8();
        test_hold();
        test_async_reset();
        test_back_to_back_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
